fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 95 +++++++++
 tb/tb_fetch_queue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Dual-slot instruction fetch queue: up to two words in and two words out per cycle,
// stored in program order in a circular buffer of DEPTH entries.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic [1:0]           in_valid,
  input  logic [1:0][31:0]     in_pc,
  input  logic [1:0][31:0]     in_instr,
  output logic                 in_ready,
  output logic [1:0]           out_hit,
  output logic [1:0][31:0]     out_pc,
  output logic [1:0][31:0]     out_instr,
  input  logic                 out_accept,
  output logic [PTR_W:0]       count,
  output logic                 err_ovf
);

  // Handshake: a write happens only in a cycle where in_valid!=0 and in_ready=1;
  // in_ready promises room for two words. On the read side every slot flagged in
  // out_hit is consumed in a cycle with out_accept=1. Slot [1] is always the older.
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);

  logic [31:0]      mem_pc    [DEPTH];
  logic [31:0]      mem_instr [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_y;
  logic [1:0]       n_enq;
  logic [1:0]       n_deq;
  logic             do_enq;

  assign in_ready = (count <= READY_MAX);
  assign do_enq   = in_ready && !flush;
  assign n_enq    = do_enq ? ({1'b0, in_valid[1]} + {1'b0, in_valid[0]}) : 2'd0;
  assign n_deq    = out_accept ? ({1'b0, out_hit[1]} + {1'b0, out_hit[0]}) : 2'd0;

  assign head_p1  = head + PTR_W'(1);
  // The younger word lands right behind the older one only when the older slot is present.
  assign tail_y   = tail + PTR_W'(in_valid[1]);

  assign out_hit[1] = (count >= CNT_W'(1));
  assign out_hit[0] = (count >= CNT_W'(2));

  always_comb begin
    out_pc    = '0;
    out_instr = '0;
    if (out_hit[1]) begin
      out_pc[1]    = mem_pc[head];
      out_instr[1] = mem_instr[head];
    end
    if (out_hit[0]) begin
      out_pc[0]    = mem_pc[head_p1];
      out_instr[0] = mem_instr[head_p1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_enq && in_valid[1]) begin
        mem_pc[tail]    <= in_pc[1];
        mem_instr[tail] <= in_instr[1];
      end
      if (do_enq && in_valid[0]) begin
        mem_pc[tail_y]    <= in_pc[0];
        mem_instr[tail_y] <= in_instr[0];
      end
      if (!in_ready && (in_valid != 2'b00)) begin
        err_ovf <= 1'b1;
      end
      tail  <= tail + PTR_W'(n_enq);
      head  <= head + PTR_W'(n_deq);
      count <= count + CNT_W'(n_enq) - CNT_W'(n_deq);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then randomized traffic, all checked
// against a program-order queue model of the fetch buffer.
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic             clk = 1'b0;
  logic             resetn;
  logic             flush;
  logic [1:0]       in_valid;
  logic [1:0][31:0] in_pc;
  logic [1:0][31:0] in_instr;
  logic             in_ready;
  logic [1:0]       out_hit;
  logic [1:0][31:0] out_pc;
  logic [1:0][31:0] out_instr;
  logic             out_accept;
  logic [PTR_W:0]   count;
  logic             err_ovf;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: words in program order, front is the oldest
  logic [31:0] q_pc[$];
  logic [31:0] q_in[$];
  bit          model_ovf = 0;

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .out_hit    (out_hit),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_accept (out_accept),
    .count      (count),
    .err_ovf    (err_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int sz;
    sz = q_pc.size();
    chk({tag, "_count"}, 64'(count), 64'(sz));
    chk({tag, "_ready"}, 64'(in_ready), 64'(sz <= DEPTH - 2));
    chk({tag, "_hit"}, 64'(out_hit), {62'd0, sz >= 1, sz >= 2});
    chk({tag, "_pc1"}, 64'(out_pc[1]), (sz >= 1) ? 64'(q_pc[0]) : 64'd0);
    chk({tag, "_pc0"}, 64'(out_pc[0]), (sz >= 2) ? 64'(q_pc[1]) : 64'd0);
    chk({tag, "_in1"}, 64'(out_instr[1]), (sz >= 1) ? 64'(q_in[0]) : 64'd0);
    chk({tag, "_in0"}, 64'(out_instr[0]), (sz >= 2) ? 64'(q_in[1]) : 64'd0);
    chk({tag, "_ovf"}, 64'(err_ovf), 64'(model_ovf));
  endtask

  task automatic model_update(input logic [1:0] v, input logic [31:0] pc1, pc0,
                              input logic [31:0] i1, i0, input logic acc, input logic fl);
    int sz;
    int ndeq;
    sz = q_pc.size();
    if (fl) begin
      q_pc.delete();
      q_in.delete();
    end else begin
      ndeq = acc ? ((sz >= 2) ? 2 : sz) : 0;
      for (int k = 0; k < ndeq; k++) begin
        void'(q_pc.pop_front());
        void'(q_in.pop_front());
      end
      if (v != 2'b00) begin
        if (sz <= DEPTH - 2) begin
          if (v[1]) begin q_pc.push_back(pc1); q_in.push_back(i1); end
          if (v[0]) begin q_pc.push_back(pc0); q_in.push_back(i0); end
        end else begin
          model_ovf = 1;
        end
      end
    end
  endtask

  // Called just after a falling edge: drive, check pre-edge outputs, clock, update model.
  task automatic step(input string tag, input logic [1:0] v, input logic [31:0] pc1, pc0,
                      input logic acc, input logic fl);
    logic [31:0] i1;
    logic [31:0] i0;
    i1 = $urandom;
    i0 = $urandom;
    in_valid    = v;
    in_pc[1]    = pc1;
    in_pc[0]    = pc0;
    in_instr[1] = i1;
    in_instr[0] = i0;
    out_accept  = acc;
    flush       = fl;
    check_outputs(tag);
    @(posedge clk);
    model_update(v, pc1, pc0, i1, i0, acc, fl);
    @(negedge clk);
    in_valid   = 2'b00;
    out_accept = 1'b0;
    flush      = 1'b0;
  endtask

  initial begin
    logic [31:0] next_pc;
    int          sent;
    int          consumed;
    int          iter;
    logic [1:0]  v;
    logic        acc;

    resetn     = 1'b0;
    flush      = 1'b0;
    in_valid   = 2'b00;
    in_pc      = '0;
    in_instr   = '0;
    out_accept = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("reset");
    resetn = 1'b1;
    @(negedge clk);

    // first pair becomes visible the following cycle, in order
    step("req029_a", 2'b11, 32'hBFC00000, 32'hBFC00004, 1'b0, 1'b0);
    chk("req029_pc1", 64'(out_pc[1]), 64'hBFC00000);
    chk("req029_pc0", 64'(out_pc[0]), 64'hBFC00004);
    chk("req029_count", 64'(count), 64'd2);

    // fill to 7, then an overflowing write is dropped and flagged
    step("req030_a", 2'b11, 32'h100, 32'h104, 1'b0, 1'b0);
    step("req030_b", 2'b11, 32'h108, 32'h10C, 1'b0, 1'b0);
    step("req030_c", 2'b10, 32'h110, 32'h0, 1'b0, 1'b0);
    chk("req030_ready", 64'(in_ready), 64'd0);
    step("req030_d", 2'b11, 32'h114, 32'h118, 1'b0, 1'b0);
    chk("req030_count", 64'(count), 64'd7);
    chk("req030_ovf", 64'(err_ovf), 64'd1);

    // flush with a simultaneous write: everything discarded, overflow flag stays
    step("req033_a", 2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
    step("req033_b", 2'b11, 32'h200, 32'h204, 1'b0, 1'b0);
    step("req033_c", 2'b11, 32'h208, 32'h20C, 1'b0, 1'b0);
    step("req033_d", 2'b01, 32'h0, 32'h210, 1'b0, 1'b0);
    chk("req033_count5", 64'(count), 64'd5);
    step("req033_e", 2'b11, 32'h214, 32'h218, 1'b0, 1'b1);
    chk("req033_count", 64'(count), 64'd0);
    chk("req033_hit", 64'(out_hit), 64'd0);
    chk("req033_ready", 64'(in_ready), 64'd1);
    chk("req033_ovf", 64'(err_ovf), 64'd1);

    // simultaneous dequeue of one and enqueue of two
    step("req031_a", 2'b01, 32'h0, 32'h300, 1'b0, 1'b0);
    step("req031_b", 2'b11, 32'h304, 32'h308, 1'b1, 1'b0);
    chk("req031_count", 64'(count), 64'd2);
    chk("req031_pc1", 64'(out_pc[1]), 64'h304);
    chk("req031_pc0", 64'(out_pc[0]), 64'h308);

    // single younger-slot write followed by single older-slot write
    step("req034_a", 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    step("req034_b", 2'b01, 32'h0, 32'h80000010, 1'b0, 1'b0);
    step("req034_c", 2'b10, 32'h80000014, 32'h0, 1'b0, 1'b0);
    chk("req034_pc1", 64'(out_pc[1]), 64'h80000010);
    chk("req034_pc0", 64'(out_pc[0]), 64'h80000014);

    // 20 sequential PCs streamed with a toggling consumer, across pointer wrap
    step("req032_flush", 2'b00, 32'h0, 32'h0, 1'b0, 1'b1);
    next_pc  = 32'h4000;
    sent     = 0;
    consumed = 0;
    acc      = 1'b0;
    iter     = 0;
    while ((sent < 20 || q_pc.size() != 0) && iter < 100) begin
      v = (sent < 20 && q_pc.size() <= DEPTH - 2) ? 2'b11 : 2'b00;
      if (acc && q_pc.size() >= 1) begin
        chk("req032_seq1", 64'(out_pc[1]), 64'(32'h4000 + 32'(consumed * 4)));
        consumed += (q_pc.size() >= 2) ? 2 : 1;
      end
      step("req032", v, next_pc, next_pc + 32'd4, acc, 1'b0);
      if (v == 2'b11) begin
        next_pc += 32'd8;
        sent += 2;
      end
      acc = ~acc;
      iter++;
    end
    chk("req032_consumed", 64'(consumed), 64'd20);

    // asynchronous reset in the middle of a cycle clears everything at once
    step("mid_a", 2'b11, 32'h500, 32'h504, 1'b0, 1'b0);
    #2 resetn = 1'b0;
    #1;
    q_pc.delete();
    q_in.delete();
    model_ovf = 0;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_hit", 64'(out_hit), 64'd0);
    @(negedge clk);
    check_outputs("mid_rst");
    resetn = 1'b1;
    @(negedge clk);

    // randomized traffic
    next_pc = 32'h10000;
    for (int n = 0; n < 400; n++) begin
      v = 2'($urandom_range(0, 3));
      step("rand", v, next_pc, next_pc + 32'd4, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0));
      next_pc += 32'd8;
    end
    check_outputs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
